// File: rtl/vdp_pkg.sv
// rtl/vdp_pkg.sv - shared constants and control-byte opcodes for the VDP CPU port
package vdp_pkg;

    localparam logic VDP_PORT_DATA = 1'b0;
    localparam logic VDP_PORT_CTRL = 1'b1;

    // Second control byte, bits [7:6]; bit 7 set selects a register write
    typedef enum logic [1:0] {
        CTRL_RADDR  = 2'b00,
        CTRL_WADDR  = 2'b01,
        CTRL_REG    = 2'b10,
        CTRL_REG_HI = 2'b11
    } ctrl_op_t;

    localparam int F_BIT  = 7;
    localparam int IE_BIT = 5;

endpackage

// File: rtl/vdp_vram_req.sv
// rtl/vdp_vram_req.sv - single-outstanding VRAM request holder
module vdp_vram_req #(
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              start_we,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [7:0]        start_wdata,
    input  logic              vram_ack,
    output logic              vram_req,
    output logic              vram_we,
    output logic [ADDR_W-1:0] vram_addr,
    output logic [7:0]        vram_wdata,
    output logic              busy,
    output logic              done
);

    // Request fields are frozen from start until the ack cycle; a start while busy is dropped
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vram_req   <= 1'b0;
            vram_we    <= 1'b0;
            vram_addr  <= '0;
            vram_wdata <= '0;
        end else if (vram_req) begin
            if (vram_ack) begin
                vram_req <= 1'b0;
            end
        end else if (start) begin
            vram_req   <= 1'b1;
            vram_we    <= start_we;
            vram_addr  <= start_addr;
            vram_wdata <= start_wdata;
        end
    end

    assign busy = vram_req;
    assign done = vram_req & vram_ack;

endmodule

// File: rtl/vdp_cpu_port.sv
// rtl/vdp_cpu_port.sv - TMS9918-style CPU port: control protocol, read-ahead, status, VRAM access
import vdp_pkg::*;

module vdp_cpu_port #(
    parameter int ADDR_W   = 14,
    parameter int NUM_REGS = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_tick,
    input  logic                  rd_tick,
    input  logic                  a0,
    input  logic [7:0]            din,
    output logic [7:0]            dout,
    output logic                  cpu_busy,
    output logic                  vram_req,
    output logic                  vram_we,
    output logic [ADDR_W-1:0]     vram_addr,
    output logic [7:0]            vram_wdata,
    input  logic                  vram_ack,
    input  logic [7:0]            vram_rdata,
    input  logic                  frame_tick,
    input  logic [6:0]            sprite_status,
    output logic [8*NUM_REGS-1:0] regs,
    output logic                  irq
);

    logic [7:0]        latch;
    logic [7:0]        buffer;
    logic              flag;
    logic              f;
    logic              overrun;
    logic [ADDR_W-1:0] addr;
    logic              busy;
    logic              done;
    logic              start;
    logic              start_we;
    logic [ADDR_W-1:0] start_addr;
    logic [ADDR_W-1:0] setup_addr;
    ctrl_op_t          ctrl_op;

    assign setup_addr = ADDR_W'({din[5:0], latch});
    assign ctrl_op    = ctrl_op_t'(din[7:6]);

    // Requests are launched only when idle; wr_tick wins over a simultaneous rd_tick
    always_comb begin
        start      = 1'b0;
        start_we   = 1'b0;
        start_addr = addr;
        if (wr_tick) begin
            if (!busy) begin
                if (a0 == VDP_PORT_DATA) begin
                    start    = 1'b1;
                    start_we = 1'b1;
                end else if (flag && ctrl_op == CTRL_RADDR) begin
                    start      = 1'b1;
                    start_addr = setup_addr;
                end
            end
        end else if (rd_tick && a0 == VDP_PORT_DATA && !busy) begin
            start = 1'b1;
        end
    end

    vdp_vram_req #(.ADDR_W(ADDR_W)) u_req (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .start_we    (start_we),
        .start_addr  (start_addr),
        .start_wdata (din),
        .vram_ack    (vram_ack),
        .vram_req    (vram_req),
        .vram_we     (vram_we),
        .vram_addr   (vram_addr),
        .vram_wdata  (vram_wdata),
        .busy        (busy),
        .done        (done)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            regs    <= '0;
            latch   <= '0;
            flag    <= 1'b0;
            addr    <= '0;
            buffer  <= '0;
            f       <= 1'b0;
            overrun <= 1'b0;
            dout    <= '0;
        end else begin
            // Prefetch completion; a setup in the same cycle overrides addr below
            if (done && !vram_we) begin
                buffer <= vram_rdata;
                addr   <= addr + ADDR_W'(1);
            end
            if (frame_tick) begin
                f <= 1'b1;
            end
            if (wr_tick) begin
                flag <= 1'b0;
                if (a0 == VDP_PORT_CTRL) begin
                    if (!flag) begin
                        latch <= din;
                        flag  <= 1'b1;
                    end else begin
                        case (ctrl_op)
                            CTRL_REG, CTRL_REG_HI: begin
                                for (int n = 0; n < NUM_REGS; n++) begin
                                    if (din[2:0] == 3'(n)) begin
                                        regs[8*n +: 8] <= latch;
                                    end
                                end
                            end
                            CTRL_WADDR: addr <= setup_addr;
                            CTRL_RADDR: begin
                                if (busy) begin
                                    overrun <= 1'b1;
                                end else begin
                                    addr <= setup_addr;
                                end
                            end
                            default: ;
                        endcase
                    end
                end else if (busy) begin
                    overrun <= 1'b1;
                end else begin
                    buffer <= din;
                    addr   <= addr + ADDR_W'(1);
                end
            end else if (rd_tick) begin
                flag <= 1'b0;
                if (a0 == VDP_PORT_CTRL) begin
                    // Old F is returned; a coincident frame_tick keeps F set
                    dout <= {f, sprite_status};
                    if (!frame_tick) begin
                        f <= 1'b0;
                    end
                end else if (busy) begin
                    overrun <= 1'b1;
                end else begin
                    dout <= buffer;
                end
            end
        end
    end

    assign cpu_busy = busy;
    assign irq      = f & regs[8 + IE_BIT];

endmodule

// File: doc/vdp_cpu_port.md
Name: vdp_cpu_port

Overview:
- TMS9918-style CPU-side port for the FPGA VDP. It sits between the phi-synchronised IO decode ticks for ports 0x80/0x81 and the VRAM / register file that the video generator scans.
- It implements the two-byte control protocol, the address auto-increment, the read-ahead buffer and the status register with its frame interrupt.
- VRAM is reached through a single-outstanding req/ack handshake, so the memory can be shared with the display fetcher.

Parameters:
- ADDR_W, 14, VRAM address width (16 KiB).
- NUM_REGS, 8, number of write-only VDP registers, each 8 bits.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- wr_tick  in  1  one-cycle strobe: CPU IO write to the VDP port pair.
- rd_tick  in  1  one-cycle strobe: CPU IO read from the VDP port pair.
- a0  in  1  port select: 0 = data port (0x80), 1 = control port (0x81).
- din  in  8  CPU write data, valid with wr_tick.
- dout  out  8  CPU read data; registered; stable from the cycle after rd_tick until the next rd_tick.
- cpu_busy  out  1  VRAM operation pending; top level drives /WAIT from this.
- vram_req  out  1  VRAM request; held high until vram_ack.
- vram_we  out  1  1 = write, 0 = read; held with vram_req.
- vram_addr  out  ADDR_W  VRAM address; held with vram_req.
- vram_wdata  out  8  VRAM write data; held with vram_req.
- vram_ack  in  1  one-cycle completion.
- vram_rdata  in  8  read data, valid in the vram_ack cycle.
- frame_tick  in  1  one-cycle strobe at vblank start.
- sprite_status  in  7  live status bits [6:0] (5S, C, 5th-sprite number).
- regs  out  8*NUM_REGS  register file, flattened; reg n occupies bits [8n+7:8n].
- irq  out  1  active-high interrupt = F & regs[1].bit5.

Behaviour:
- Reset values (asynchronous):
  - regs = 0, latch = 0, second-byte flag = 0, addr = 0.
  - read-ahead buffer = 0, F = 0, overrun = 0.
  - dout = 0, vram_req = 0, cpu_busy = 0, irq = 0.
- A reset asserted mid-request drops vram_req immediately. A vram_ack arriving after reset is ignored.
- Control write (wr_tick, a0 = 1):
  - Flag = 0: latch <= din; flag <= 1.
  - Flag = 1, din[7] = 1: regs[din[2:0]] <= latch. Indices at or above NUM_REGS are ignored. flag <= 0.
  - Flag = 1, din[7:6] = 01 (write setup): addr <= {din[5:0], latch}; flag <= 0.
  - Flag = 1, din[7:6] = 00 (read setup): addr <= {din[5:0], latch}; issue a prefetch read at the new addr; flag <= 0.
- Data write (wr_tick, a0 = 0):
  - Issue a VRAM write of din at addr.
  - buffer <= din; addr <= addr + 1; flag <= 0.
- Data read (rd_tick, a0 = 0):
  - dout <= buffer next cycle.
  - Issue a prefetch read at addr; flag <= 0.
- Prefetch read completion: on vram_ack, buffer <= vram_rdata and addr <= addr + 1.
- Control read (rd_tick, a0 = 1):
  - dout <= {F, sprite_status} next cycle.
  - F <= 0; flag <= 0.
- Address increment wraps modulo 2^ADDR_W: 0x3FFF -> 0x0000.
- VRAM handshake:
  - vram_req is asserted the cycle after the triggering tick.
  - vram_addr, vram_we and vram_wdata are stable until the vram_ack cycle.
  - vram_req deasserts in the cycle after vram_ack.
  - cpu_busy = vram_req.
- Minimum latency is 2 cycles: tick, then req, then ack in the same cycle as req.
- A data-port tick or read-setup while cpu_busy is an overrun:
  - the access is ignored (no state change except flag <= 0);
  - the sticky overrun bit is set, cleared only by reset.
- Control writes, register writes and status reads are always accepted while busy. A setup that changes addr while busy must not alter the in-flight vram_addr.
- frame_tick sets F.
- frame_tick coinciding with a status read: dout returns the pre-set F value (0 if F was clear), and F ends the cycle set, so the interrupt is not lost.
- irq is combinational from registered F and regs[1][5].
- wr_tick and rd_tick asserted together is illegal. A bench assertion flags it; the RTL gives wr_tick priority.

Decomposition:
- Package vdp_pkg:
  - VDP_PORT_DATA = 1'b0, VDP_PORT_CTRL = 1'b1;
  - control-byte opcodes CTRL_REG = 2'b10/2'b11 (bit 7), CTRL_WADDR = 2'b01, CTRL_RADDR = 2'b00;
  - status bit index F_BIT = 7; IE bit index in reg 1 = 5.
- One natural sub-module: vdp_vram_req, the single-outstanding request holder. It owns req, we, addr, wdata and the ack capture, and exposes start / busy / done.

Test Plan:
- Control writes 0x20 then 0x81 -> regs[1] = 0x20, flag cleared. Then 0x00 then 0x87 -> regs[7] = 0x00, other regs unchanged.
- Control writes 0x00, 0x48, then data writes 0xAA, 0xBB:
  - two VRAM writes at 0x0800 (0xAA) and 0x0801 (0xBB);
  - addr ends at 0x0802; buffer = 0xBB.
- Preload VRAM[0x1234] = 0x5A and [0x1235] = 0xC3; control writes 0x34, 0x12 (read setup):
  - prefetch at 0x1234 returns 0x5A;
  - first data read gives dout = 0x5A and prefetches 0x1235;
  - second data read gives dout = 0xC3.
- Write setup to 0x3FFF, then two data writes -> VRAM writes at 0x3FFF and 0x0000.
- regs[1] = 0x20, frame_tick pulsed -> irq = 1; status read -> dout[7] = 1, irq = 0 the next cycle. frame_tick in the same cycle as a status read -> dout[7] = 0 and irq stays 1.
- Hold vram_ack low 5 cycles, then issue a data write while cpu_busy -> the write is ignored, overrun is set, and the in-flight vram_addr is unchanged. Assert reset mid-request -> vram_req = 0 and all reset values restored.
